fir_filter_mc: RTL and testbench

//  Multi-channel, parametrised FIR low-pass for the audio mix path (CDDA/PCM/FM before output).
//  One time-multiplexed signed MAC serves all taps of all channels, once per input-sample strobe.

---
 rtl/fir_filter_mc.sv | 145 ++++++++++++++
 tb/tb_fir_filter_mc.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_mc.sv
// rtl/fir_filter_mc.sv - multi-channel FIR low-pass with one shared time-multiplexed signed MAC
module fir_filter_mc #(
  parameter int CHANNELS  = 2,
  parameter int TAPS      = 10,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 18,
  parameter int COEF_FRAC = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         sample_en,
  input  logic [CHANNELS*DATA_W-1:0]   data_in,
  input  logic                         coef_we,
  input  logic [$clog2(TAPS)-1:0]      coef_addr,
  input  logic [COEF_W-1:0]            coef_data,
  output logic [CHANNELS*DATA_W-1:0]   data_out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun,
  output logic                         coef_err
);

  localparam int AW    = $clog2(TAPS);
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + AW;
  localparam int RW    = ACC_W + 1;

  localparam logic [AW:0]              TAPS_L   = (AW+1)'(TAPS);
  localparam logic [AW-1:0]            TAP_LAST = AW'(TAPS - 1);
  localparam logic [CW-1:0]            CH_LAST  = CW'(CHANNELS - 1);
  localparam logic signed [RW-1:0]     HALF     = RW'(1) << (COEF_FRAC - 1);
  localparam logic signed [RW-1:0]     SAT_MAX  = (RW'(1) << (DATA_W - 1)) - RW'(1);
  localparam logic signed [RW-1:0]     SAT_MIN  = ~SAT_MAX;
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1) << COEF_FRAC;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_ROUND} state_t;
  state_t state, state_nxt;

  logic signed [DATA_W-1:0] dly  [CHANNELS][TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [DATA_W-1:0] res  [CHANNELS];

  logic [CW-1:0]            ch, prod_ch;
  logic [AW-1:0]            tap;
  logic signed [PW-1:0]     mul_a, mul_b, prod;
  logic                     prod_vld, prod_first, prod_last;
  logic signed [ACC_W-1:0]  acc, acc_nxt;
  logic signed [RW-1:0]     rnd;
  logic signed [DATA_W-1:0] sat;
  logic                     accept, coef_ok, last_step;

  assign busy      = (state != S_IDLE);
  assign accept    = (state == S_IDLE) && sample_en;
  assign coef_ok   = coef_we && (state == S_IDLE) && !sample_en && ({1'b0, coef_addr} < TAPS_L);
  assign last_step = (ch == CH_LAST) && (tap == TAP_LAST);

  assign mul_a = PW'(dly[ch][tap]);
  assign mul_b = PW'(coef[tap]);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (sample_en) state_nxt = S_MAC;
      S_MAC:   if (last_step) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_ROUND;
      S_ROUND: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // First tap of a channel restarts the sum; the last one is rounded and clamped into res.
  always_comb begin
    acc_nxt = prod_first ? ACC_W'(prod) : acc + ACC_W'(prod);
    rnd     = (RW'(acc_nxt) + HALF) >>> COEF_FRAC;
    if (rnd > SAT_MAX)
      sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (rnd < SAT_MIN)
      sat = {1'b1, {(DATA_W-1){1'b0}}};
    else
      sat = rnd[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      ch         <= '0;
      tap        <= '0;
      prod       <= '0;
      prod_ch    <= '0;
      prod_vld   <= 1'b0;
      prod_first <= 1'b0;
      prod_last  <= 1'b0;
      acc        <= '0;
      data_out   <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      coef_err   <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        res[k] <= '0;
        for (int i = 0; i < TAPS; i++) dly[k][i] <= '0;
      end
      for (int i = 0; i < TAPS; i++) coef[i] <= (i == 0) ? COEF_ONE : '0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state == S_ROUND);
      overrun   <= sample_en && busy;
      coef_err  <= coef_we && !coef_ok;
      prod_vld  <= (state == S_MAC);

      if (accept) begin
        ch  <= '0;
        tap <= '0;
        for (int k = 0; k < CHANNELS; k++) begin
          dly[k][0] <= data_in[k*DATA_W +: DATA_W];
          for (int i = 1; i < TAPS; i++) dly[k][i] <= dly[k][i-1];
        end
      end

      if (coef_ok) coef[coef_addr] <= coef_data;

      if (state == S_MAC) begin
        prod       <= mul_a * mul_b;
        prod_first <= (tap == '0);
        prod_last  <= (tap == TAP_LAST);
        prod_ch    <= ch;
        if (tap == TAP_LAST) begin
          tap <= '0;
          ch  <= ch + CW'(1);
        end else begin
          tap <= tap + AW'(1);
        end
      end

      if (prod_vld) begin
        acc <= acc_nxt;
        if (prod_last) res[prod_ch] <= sat;
      end

      if (state == S_ROUND)
        for (int k = 0; k < CHANNELS; k++) data_out[k*DATA_W +: DATA_W] <= res[k];
    end
  end

endmodule

// File: tb/tb_fir_filter_mc.sv
// tb/tb_fir_filter_mc.sv - randomized self-checking bench for fir_filter_mc against an arithmetic model
module tb_fir_filter_mc;
  localparam int CH = 2;
  localparam int TP = 10;
  localparam int DW = 16;
  localparam int CW = 18;
  localparam int CF = 16;
  localparam int LAT = CH*TP + 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              sample_en;
  logic [CH*DW-1:0]  data_in;
  logic              coef_we;
  logic [3:0]        coef_addr;
  logic [CW-1:0]     coef_data;
  logic [CH*DW-1:0]  data_out;
  logic              out_valid, busy, overrun, coef_err;

  fir_filter_mc dut (
    .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .data_in(data_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .data_out(data_out), .out_valid(out_valid), .busy(busy),
    .overrun(overrun), .coef_err(coef_err)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint hist [CH][TP];
  longint cf   [TP];
  longint last_out [CH];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < CH; k++)
      for (int i = 0; i < TP; i++) hist[k][i] = 0;
    for (int i = 0; i < TP; i++) cf[i] = 0;
    cf[0] = longint'(1) << CF;
  endtask

  function automatic longint model_out(input int k);
    longint acc = 0;
    for (int i = 0; i < TP; i++) acc += cf[i] * hist[k][i];
    acc = (acc + (longint'(1) << (CF-1))) >>> CF;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  function automatic longint dout(input int k);
    logic signed [DW-1:0] v;
    v = data_out[k*DW +: DW];
    return longint'(v);
  endfunction

  // mode 0: plain; 1: sample_en + coef_we while busy; 2: coef_we together with the accepted sample_en
  task automatic send(input longint s0, input longint s1, input int mode);
    int cyc;
    bit seen;
    @(negedge clk);
    sample_en = 1'b1;
    data_in[15:0]  = s0[15:0];
    data_in[31:16] = s1[15:0];
    if (mode == 2) begin
      coef_we = 1'b1; coef_addr = 4'd1; coef_data = 18'd777;
    end
    for (int k = 0; k < CH; k++)
      for (int i = TP-1; i > 0; i--) hist[k][i] = hist[k][i-1];
    hist[0][0] = s0;
    hist[1][0] = s1;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        sample_en = 1'b0;
        check("busy_after_accept", busy, 1);
        if (mode == 2) begin
          check("coef_err_with_sample", coef_err, 1);
          coef_we = 1'b0;
        end
      end
      if (mode == 1 && cyc == 5) begin
        sample_en = 1'b1; data_in = ~data_in;
        coef_we = 1'b1; coef_addr = 4'd0; coef_data = 18'h01234;
      end
      if (mode == 1 && cyc == 6) begin
        check("overrun_pulse", overrun, 1);
        check("coef_err_busy", coef_err, 1);
        sample_en = 1'b0;
        coef_we = 1'b0;
      end
      seen = out_valid;
    end
    check("latency", cyc, LAT);
    check("busy_at_valid", busy, 0);
    for (int k = 0; k < CH; k++) begin
      last_out[k] = dout(k);
      check($sformatf("data_ch%0d", k), last_out[k], model_out(k));
    end
  endtask

  task automatic wcoef(input int addr, input longint val, input bit exp_err);
    @(negedge clk);
    coef_we = 1'b1;
    coef_addr = 4'(addr);
    coef_data = val[CW-1:0];
    @(posedge clk); #1;
    check($sformatf("coef_err_addr%0d", addr), coef_err, longint'(exp_err));
    coef_we = 1'b0;
    if (!exp_err) cf[addr] = val;
  endtask

  initial begin
    int n_valid;
    reset_n = 1'b0; sample_en = 1'b0; data_in = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", data_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_coef_err", coef_err, 0);
    @(negedge clk); reset_n = 1'b1;

    send(1234, -5000, 0);

    for (int i = 0; i < TP; i++) send(0, 0, 0);
    wcoef(0, 89, 0);   wcoef(1, 795, 0);  wcoef(2, 2665, 0); wcoef(3, 5374, 0);
    wcoef(4, 7461, 0); wcoef(5, 7461, 0); wcoef(6, 5374, 0); wcoef(7, 2665, 0);
    wcoef(8, 795, 0);  wcoef(9, 89, 0);
    send(32767, 0, 0);
    send(0, 0, 0);
    check("impulse_tap1", last_out[0], 397);
    for (int i = 0; i < TP-1; i++) send(0, 0, 0);
    check("impulse_tail_ch1", last_out[1], 0);

    for (int i = 0; i < TP; i++) wcoef(i, 65536, 0);
    for (int i = 0; i < TP+1; i++) send(32767, -32768, 0);
    check("sat_pos", last_out[0], 32767);
    check("sat_neg", last_out[1], -32768);
    for (int i = 0; i < TP; i++) send(-32768, 32767, 0);

    send(1000, -2000, 1);
    send(-3000, 4000, 2);
    wcoef(12, 5, 1);
    wcoef(15, 5, 1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < TP; i++)
        wcoef(i, longint'($urandom_range(0, 131072)) - 65536, 0);
      wcoef(TP + int'($urandom_range(0, 5)), 99, 1);
      for (int s = 0; s < 4; s++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        send(longint'($urandom_range(0, 65535)) - 32768,
             longint'($urandom_range(0, 65535)) - 32768, 0);
      end
    end

    @(negedge clk);
    sample_en = 1'b1; data_in = {16'd500, 16'd700};
    @(posedge clk); #1;
    sample_en = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_data_out", data_out, 0);
    check("abort_busy", busy, 0);
    @(negedge clk); reset_n = 1'b1;
    model_reset();
    n_valid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) n_valid++;
    end
    check("abort_no_valid", n_valid, 0);
    send(1234, -5000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
